// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: BCD width, segment
// patterns ({g,f,e,d,c,b,a}, active-high) and the slot-phase enum.
package seg7_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Phase within a digit slot: enables off (anti-ghosting) or digit shown.
    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder. Codes 10-15 are not valid BCD and
// render as a single dash (segment g) so bad data is visible on the display.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);

    // Map each nibble to its segment pattern, dash for anything above 9.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. One shared decoder is fed by a
// nibble mux on the active digit index. Loaded data waits in a shadow register
// and is moved to the display register only at the frame wrap, so a frame is
// never drawn with a mix of old and new digits. All outputs are registered and
// reflect the (tick, idx, disp) state of the previous cycle.
// Handshake: load_syn is a level-sampled strobe with no back-pressure; every
// cycle it is high Din/dp_in are captured (last capture before a wrap wins).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int LZB          = 1
) (
    input  logic                          clk,
    input  logic                          rst_syn,
    input  logic                          load_syn,
    input  logic [BCD_W*NUM_DIGITS-1:0]   Din,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic                          frame_done,
    output slot_e                         dbg_slot
);

    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW     = BCD_W * NUM_DIGITS;

    // Reject parameter sets the scan timing cannot support.
    generate
        if (SCAN_DIV < 2 || BLANK_CYCLES >= SCAN_DIV || NUM_DIGITS < 1) begin : g_bad_params
            $error("seg7_scan_ctrl: illegal parameters (SCAN_DIV>=2, BLANK_CYCLES<SCAN_DIV, NUM_DIGITS>=1)");
        end
    endgenerate

    logic [TICK_W-1:0]     r_tick;
    logic [IDX_W-1:0]      r_idx;
    logic [DW-1:0]         r_disp;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [DW-1:0]         r_shadow;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic                  r_pending;

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_done;
    slot_e                 r_slot;

    logic                  w_tick_end;
    logic                  w_wrap;
    slot_e                 w_slot;
    logic [BCD_W-1:0]      w_nibble;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic [NUM_DIGITS-1:0] w_an_onehot;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic                  w_run;
    logic [6:0]            w_seg_dec;

    assign w_tick_end = (r_tick == TICK_W'(SCAN_DIV - 1));
    assign w_wrap     = w_tick_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Slot phase: the first BLANK_CYCLES ticks of every slot keep all enables off.
    always_comb begin
        w_slot = SLOT_SHOW;
        if (r_tick < TICK_W'(BLANK_CYCLES)) begin
            w_slot = SLOT_BLANK;
        end
    end

    // Tick and digit-index counters; idx advances at the end of each slot.
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else if (w_tick_end) begin
            r_tick <= '0;
            r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    // Shadow capture and frame-boundary transfer; a load in the wrap cycle goes straight to disp.
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_disp      <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (load_syn) begin
                r_shadow    <= Din;
                r_shadow_dp <= dp_in;
            end
            if (load_syn && w_wrap) begin
                r_disp    <= Din;
                r_disp_dp <= dp_in;
                r_pending <= 1'b0;
            end else if (load_syn) begin
                r_pending <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
                r_pending <= 1'b0;
            end
        end
    end

    // Leading-zero blanking: digit i>0 is dark when it and every higher digit are 0 with no dp.
    always_comb begin
        w_lz_blank = '0;
        w_run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run         = w_run & (r_disp[i*BCD_W +: BCD_W] == '0) & ~r_disp_dp[i];
            w_lz_blank[i] = (LZB != 0) & w_run;
        end
    end

    // Select the active digit's nibble, dp, blank flag and one-hot enable.
    always_comb begin
        w_nibble    = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble       = r_disp[i*BCD_W +: BCD_W];
                w_cur_dp       = r_disp_dp[i];
                w_cur_blank    = w_lz_blank[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .i_bcd (w_nibble),
        .o_seg (w_seg_dec)
    );

    // Output registers: drive the pins from this cycle's counter and display state.
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_an         <= '0;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
            r_slot       <= SLOT_BLANK;
        end else begin
            r_frame_done <= w_wrap;
            r_slot       <= w_slot;
            if (w_slot == SLOT_SHOW && !w_cur_blank) begin
                r_an  <= w_an_onehot;
                r_seg <= w_seg_dec;
                r_dp  <= w_cur_dp;
            end else begin
                r_an  <= '0;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
    assign dbg_slot   = r_slot;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a 4-digit instance with SCAN_DIV=4, BLANK_CYCLES=1,
// LZB=1, and a second 4-digit instance with SCAN_DIV=2 and LZB=0.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] L0 = 7'b0111111;
  localparam logic [6:0] L1 = 7'b0000110;
  localparam logic [6:0] L2 = 7'b1011011;
  localparam logic [6:0] L3 = 7'b1001111;
  localparam logic [6:0] L4 = 7'b1100110;
  localparam logic [6:0] L5 = 7'b1101101;
  localparam logic [6:0] L6 = 7'b1111101;
  localparam logic [6:0] L7 = 7'b0000111;
  localparam logic [6:0] L8 = 7'b1111111;
  localparam logic [6:0] L9 = 7'b1101111;
  localparam logic [6:0] LD = 7'b1000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_syn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 ----------------
  logic        load_syn = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  seg7_pkg::slot_e dbg_slot;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .LZB(1)) u_dut (
    .clk        (clk),
    .rst_syn    (rst_syn),
    .load_syn   (load_syn),
    .Din        (din),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done),
    .dbg_slot   (dbg_slot)
  );

  // ---------------- DUT 2 ----------------
  logic        load2 = 1'b0;
  logic [15:0] din2 = '0;
  logic [3:0]  dp_in2 = '0;
  logic [3:0]  an2;
  logic [6:0]  seg2;
  logic        dp2;
  logic        fd2;
  seg7_pkg::slot_e dbg2;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(2), .BLANK_CYCLES(1), .LZB(0)) u_dut2 (
    .clk        (clk),
    .rst_syn    (rst_syn),
    .load_syn   (load2),
    .Din        (din2),
    .dp_in      (dp_in2),
    .an         (an2),
    .seg        (seg2),
    .dp         (dp2),
    .frame_done (fd2),
    .dbg_slot   (dbg2)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    string             name;
    logic [15:0]       din;
    logic [3:0]        dpi;
    logic [3:0]        shown;
    logic [3:0][6:0]   seg;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {an, seg, dp, frame_done, show}
  function automatic logic [13:0] obs1();
    return {an, seg, dp, frame_done, (dbg_slot == seg7_pkg::SLOT_SHOW)};
  endfunction

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    chk("frame_done_seen", {31'b0, frame_done}, 32'd1);
  endtask

  task automatic load1(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load_syn = 1'b1;
    din      = v;
    dp_in    = d;
    @(negedge clk);
    load_syn = 1'b0;
  endtask

  // Called right after frame_done was sampled high: checks the next 16 cycles
  // against v, optionally driving up to two one-cycle loads at samples ld_j1/ld_j2.
  task automatic check_frame(input vec_t v, input int ld_j1, input logic [15:0] ld_v1,
                             input int ld_j2, input logic [15:0] ld_v2);
    for (int j = 0; j < 16; j++) begin
      int s;
      int t;
      logic fd;
      logic [13:0] e;
      @(negedge clk);
      s  = j / 4;
      t  = j % 4;
      fd = (j == 15);
      if (t == 0)
        e = {4'b0000, 7'b0, 1'b0, fd, 1'b0};
      else if (v.shown[s])
        e = {4'b0001 << s, v.seg[s], v.dpi[s], fd, 1'b1};
      else
        e = {4'b0000, 7'b0, 1'b0, fd, 1'b1};
      chk($sformatf("frame_%s_j%0d", v.name, j), {18'b0, obs1()}, {18'b0, e});
      if (j == ld_j1) begin
        load_syn = 1'b1; din = ld_v1; dp_in = 4'b0;
      end else if (j == ld_j2) begin
        load_syn = 1'b1; din = ld_v2; dp_in = 4'b0;
      end else begin
        load_syn = 1'b0;
      end
    end
    load_syn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0][6:0] seg2_exp;
    int n;

    vecs[0]  = '{"1234",   16'h1234, 4'b0000, 4'b1111, {L1, L2, L3, L4}};
    vecs[1]  = '{"0045",   16'h0045, 4'b0000, 4'b0011, {L0, L0, L4, L5}};
    vecs[2]  = '{"0045dp", 16'h0045, 4'b1000, 4'b1111, {L0, L0, L4, L5}};
    vecs[3]  = '{"0000",   16'h0000, 4'b0000, 4'b0001, {L0, L0, L0, L0}};
    vecs[4]  = '{"00A0",   16'h00A0, 4'b0000, 4'b0011, {L0, L0, LD, L0}};
    vecs[5]  = '{"9999dp", 16'h9999, 4'b0101, 4'b1111, {L9, L9, L9, L9}};
    vecs[6]  = '{"0F08",   16'h0F08, 4'b0000, 4'b0111, {L0, LD, L0, L8}};
    vecs[7]  = '{"7600dp", 16'h7600, 4'b0001, 4'b1111, {L7, L6, L0, L0}};
    vecs[8]  = '{"5678",   16'h5678, 4'b0000, 4'b1111, {L5, L6, L7, L8}};
    vecs[9]  = '{"0001",   16'h0001, 4'b0000, 4'b0001, {L0, L0, L0, L1}};
    vecs[10] = '{"9999",   16'h9999, 4'b0000, 4'b1111, {L9, L9, L9, L9}};

    // Reset held: all outputs low.
    repeat (3) @(negedge clk);
    chk("reset_held", {18'b0, obs1()}, 32'd0);
    chk("reset_held2", {25'b0, an2, seg2[0], dp2, fd2}, 32'd0);
    rst_syn = 1'b1;
    din2    = 16'h0021;
    @(negedge clk);
    chk("post_reset_blank", {18'b0, obs1()}, 32'd0);
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    chk("post_reset_show0", {18'b0, obs1()}, {18'b0, 4'b0001, L0, 1'b0, 1'b0, 1'b1});

    // SCAN_DIV=2, LZB=0: one blank and one show cycle per slot, zeros shown.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd2 !== 1'b1 && n < 64);
    chk("fd2_seen", {31'b0, fd2}, 32'd1);
    seg2_exp = {L0, L0, L2, L1};
    for (int j = 0; j < 8; j++) begin
      logic [12:0] e2;
      @(negedge clk);
      if (j % 2 == 0)
        e2 = {4'b0000, 7'b0, 1'b0, (j == 7)};
      else
        e2 = {4'b0001 << (j / 2), seg2_exp[j / 2], 1'b0, (j == 7)};
      chk($sformatf("div2_j%0d", j), {19'b0, an2, seg2, dp2, fd2}, {19'b0, e2});
    end

    // Table of load/display vectors.
    for (int i = 0; i < 8; i++) begin
      load1(vecs[i].din, vecs[i].dpi);
      wait_fd();
      check_frame(vecs[i], -1, 16'h0, -1, 16'h0);
    end

    // No tearing: load 5678 during digit 1, current frame stays 1234.
    load1(16'h1234, 4'b0000);
    wait_fd();
    check_frame(vecs[0], 5, 16'h5678, -1, 16'h0);
    check_frame(vecs[8], 14, 16'h9999, -1, 16'h0);   // load lands in wrap cycle
    check_frame(vecs[10], 2, 16'h2222, 8, 16'h0001); // two loads, last wins
    check_frame(vecs[9], -1, 16'h0, -1, 16'h0);

    // Asynchronous reset mid-slot: outputs clear without a clock edge.
    load1(16'h1234, 4'b0000);
    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an === 4'b0000 && n < 32);
    chk("an_active_before_reset", {31'b0, (an !== 4'b0000)}, 32'd1);
    #2 rst_syn = 1'b0;
    #1;
    chk("async_reset_clears", {18'b0, obs1()}, 32'd0);
    @(negedge clk);
    rst_syn = 1'b1;
    @(negedge clk);
    chk("rereset_blank", {18'b0, obs1()}, 32'd0);
    @(negedge clk);
    chk("rereset_show0", {18'b0, obs1()}, {18'b0, 4'b0001, L0, 1'b0, 1'b0, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
